// File: rtl/bbc_sysvia_pkg.sv
// Shared constants for the system VIA peripheral controller: addressable latch bit map,
// keyboard matrix geometry and the latch reset value.
package bbc_sysvia_pkg;

    localparam int unsigned LB_SOUND_WE  = 0;
    localparam int unsigned LB_SPEECH_RD = 1;
    localparam int unsigned LB_SPEECH_WE = 2;
    localparam int unsigned LB_KB_AUTO   = 3;
    localparam int unsigned LB_SCREEN_LO = 4;
    localparam int unsigned LB_SCREEN_HI = 5;
    localparam int unsigned LB_CAPS      = 6;
    localparam int unsigned LB_SHIFT     = 7;

    localparam int unsigned NUM_COLS = 10;
    localparam int unsigned NUM_ROWS = 8;

    localparam logic [7:0] LATCH_RESET = 8'h0F;

endpackage

// File: rtl/bbc_kb_matrix_mux.sv
// Combinational keyboard matrix view: DIP switches overlay row 0 of columns 2 and up,
// plus the OR of rows 1..7 of the selected column for the keyboard interrupt.
module bbc_kb_matrix_mux #(
    parameter int unsigned NUM_COLS = 10
) (
    input  logic [NUM_COLS*8-1:0] keys_i,
    input  logic [7:0]            dip_i,
    input  logic [3:0]            col_i,
    input  logic [2:0]            row_i,
    output logic                  key_o,
    output logic                  col_any_o
);

    logic [3:0] dip_sel;

    always_comb begin
        key_o     = 1'b0;
        col_any_o = 1'b0;
        dip_sel   = col_i - 4'd2;
        if (32'(col_i) < NUM_COLS) begin
            if (row_i == 3'd0 && col_i >= 4'd2) begin
                key_o = dip_sel[3] ? 1'b0 : dip_i[dip_sel[2:0]];
            end else begin
                key_o = keys_i[{col_i, row_i}];
            end
            // Row 0 carries the DIP switches and never raises the interrupt.
            for (int r = 1; r < 8; r++) begin
                col_any_o = col_any_o | keys_i[{col_i, 3'(r)}];
            end
        end
    end

endmodule

// File: rtl/bbc_sysvia_periph_ctrl.sv
// System VIA peripheral side: addressable latch, keyboard autoscan/manual read and
// sound-chip write sequencing on the 1 MHz bus clock.
module bbc_sysvia_periph_ctrl #(
    parameter int unsigned NUM_COLS    = bbc_sysvia_pkg::NUM_COLS,
    parameter int unsigned NUM_ROWS    = bbc_sysvia_pkg::NUM_ROWS,
    parameter logic [7:0]  LATCH_RESET = bbc_sysvia_pkg::LATCH_RESET
) (
    input  logic                         PHI_2,
    input  logic                         RESET,
    input  logic [3:0]                   VIA_PB,
    input  logic [7:0]                   VIA_PA,
    input  logic [NUM_COLS*NUM_ROWS-1:0] KEYS,
    input  logic [7:0]                   DIP,
    output logic                         KB_PA7,
    output logic                         KB_CA2,
    output logic [3:0]                   SCAN_COL,
    output logic [7:0]                   LATCH,
    output logic [7:0]                   SOUND_DATA,
    output logic                         SOUND_WR
);

    import bbc_sysvia_pkg::*;

    logic [7:0] latch_q, latch_d;
    logic [3:0] scan_col_q, scan_col_d;
    logic       kb_pa7_q, kb_pa7_d;
    logic       kb_ca2_q, kb_ca2_d;
    logic [7:0] sound_data_q, sound_data_d;
    logic       sound_wr_q, sound_wr_d;
    logic       prev_we_q, prev_we_d;
    logic       key_sel;
    logic       col_any;

    bbc_kb_matrix_mux #(
        .NUM_COLS(NUM_COLS)
    ) u_mux (
        .keys_i   (KEYS),
        .dip_i    (DIP),
        .col_i    (scan_col_q),
        .row_i    (VIA_PA[6:4]),
        .key_o    (key_sel),
        .col_any_o(col_any)
    );

    always_comb begin
        latch_d                = latch_q;
        latch_d[VIA_PB[2:0]]   = VIA_PB[3];

        // Counter resumes from wherever manual mode left it; out-of-range restarts at 0.
        if (latch_q[LB_KB_AUTO]) begin
            scan_col_d = (32'(scan_col_q) >= NUM_COLS - 1) ? 4'd0 : scan_col_q + 4'd1;
        end else begin
            scan_col_d = VIA_PA[3:0];
        end

        kb_pa7_d = key_sel;
        kb_ca2_d = col_any;

        prev_we_d    = latch_q[LB_SOUND_WE];
        sound_wr_d   = prev_we_q & ~latch_q[LB_SOUND_WE];
        sound_data_d = sound_wr_d ? VIA_PA : sound_data_q;
    end

    always_ff @(posedge PHI_2) begin
        if (RESET) begin
            latch_q      <= LATCH_RESET;
            scan_col_q   <= 4'd0;
            kb_pa7_q     <= 1'b0;
            kb_ca2_q     <= 1'b0;
            sound_data_q <= 8'h00;
            sound_wr_q   <= 1'b0;
            prev_we_q    <= 1'b1;
        end else begin
            latch_q      <= latch_d;
            scan_col_q   <= scan_col_d;
            kb_pa7_q     <= kb_pa7_d;
            kb_ca2_q     <= kb_ca2_d;
            sound_data_q <= sound_data_d;
            sound_wr_q   <= sound_wr_d;
            prev_we_q    <= prev_we_d;
        end
    end

    assign LATCH      = latch_q;
    assign SCAN_COL   = scan_col_q;
    assign KB_PA7     = kb_pa7_q;
    assign KB_CA2     = kb_ca2_q;
    assign SOUND_DATA = sound_data_q;
    assign SOUND_WR   = sound_wr_q;

endmodule

// File: doc/bbc_sysvia_periph_ctrl.md
Name: bbc_sysvia_periph_ctrl

Overview:
Controller for the system VIA's peripheral side. It models the 8-bit addressable latch that the VIA drives through PB[3:0]. It runs the keyboard matrix autoscan and manual-read sequencing, returning the key state on PA7 and the interrupt on CA2. It also sequences sound-chip writes, capturing PA data on the latch's sound-write-enable strobe. It sits between the system VIA port pins and the keyboard matrix, DIP switches and sound generator, on the 1 MHz bus clock.

Parameters:
NUM_COLS, 10, keyboard matrix columns; the scan counter wraps at NUM_COLS-1
NUM_ROWS, 8, keyboard matrix rows; fixed by the 3-bit row select
LATCH_RESET, 8'h0F, addressable latch value after reset (sound/speech strobes inactive, autoscan on)

Ports:
PHI_2  in  1  1 MHz bus clock; all state changes on the rising edge
RESET  in  1  synchronous, active-high reset
VIA_PB  in  4  VIA port B outputs: [2:0] latch address, [3] latch data
VIA_PA  in  8  VIA port A pin values as driven by the VIA: [3:0] column, [6:4] row; full byte is sound data
KEYS  in  NUM_COLS*NUM_ROWS  key pressed = 1; index = col*8 + row
DIP  in  8  start-up DIP switches, on = 1
KB_PA7  out  1  selected-key state, to VIA PA7 input
KB_CA2  out  1  keyboard interrupt, to VIA CA2
SCAN_COL  out  4  current column under scan
LATCH  out  8  latch state: [0] nSOUND_WE, [1] nSPEECH_RD, [2] nSPEECH_WE, [3] KB autoscan enable, [5:4] screen size, [6] CAPS LED, [7] SHIFT LED
SOUND_DATA  out  8  byte captured for the sound generator
SOUND_WR  out  1  one-cycle sound write strobe

Behaviour:
- Reset (RESET=1 at a clock edge): LATCH=LATCH_RESET, SCAN_COL=0, KB_PA7=0, KB_CA2=0, SOUND_DATA=0, SOUND_WR=0, prev-latch0 register=1. Reset mid-operation aborts any pending strobe: no SOUND_WR is issued for a falling edge that coincides with reset.
- Latch: every edge, LATCH[VIA_PB[2:0]] <= VIA_PB[3]; the other bits hold. Effect is visible 1 cycle later.
- Effective matrix M(col,row):
  - row 0, col 0..1 = KEYS
  - row 0, col 2..9 = DIP[col-2]
  - rows 1..7 = KEYS
  - col >= NUM_COLS = 0
- Mode AUTOSCAN (LATCH[3]=1):
  - SCAN_COL increments each cycle and wraps 9 -> 0.
  - If entered with SCAN_COL > 9, the next value is 0.
- Mode MANUAL (LATCH[3]=0): SCAN_COL <= VIA_PA[3:0] each cycle; values 10..15 are passed through.
- The mode switch takes effect on the edge after LATCH[3] changes. The counter resumes from the current SCAN_COL; there is no reset to 0.
- KB_CA2 (registered, both modes): KB_CA2 <= OR over rows 1..7 of M(SCAN_COL,row). Row 0 never raises CA2.
- KB_PA7 (registered): KB_PA7 <= M(SCAN_COL, VIA_PA[6:4]).
  - Valid in MANUAL mode 2 edges after PA is set: SCAN_COL settles on the first edge, KB_PA7 on the second.
  - Don't-care in AUTOSCAN mode but still driven.
- Sound sequencer:
  - On any edge where prev-latch0=1 and LATCH[0]=0 (falling edge of the registered latch bit): SOUND_DATA <= VIA_PA, and SOUND_WR=1 for exactly that one cycle.
  - LATCH[0] held low produces no further strobes.
  - Re-arming requires LATCH[0] to return to 1 for at least one cycle.
- Simultaneous events: a latch write to bit 0 and a PA change in the same cycle are resolved by the 1-cycle latch latency. SOUND_DATA takes the PA value present one cycle after the PB write.
- Width rules: SCAN_COL is 4-bit; matrix index is 7-bit (col*8+row); out-of-range index reads 0.

Decomposition:
- Package bbc_sysvia_pkg: latch bit-index constants (LB_SOUND_WE=0, LB_SPEECH_RD=1, LB_SPEECH_WE=2, LB_KB_AUTO=3, LB_SCREEN=4..5, LB_CAPS=6, LB_SHIFT=7), NUM_COLS/NUM_ROWS, LATCH_RESET.
- Sub-module bbc_kb_matrix_mux: combinational M(col,row) with DIP overlay and the column-OR for CA2. Registers stay in the parent.

Test Plan:
- Reset, then idle 20 cycles, no keys -> LATCH=8'h0F; SCAN_COL sequence 1,2,...,9,0,1; KB_CA2=0 throughout.
- Autoscan, KEYS[5*8+3]=1 (col 5, row 3) -> KB_CA2=1 exactly in the cycle after SCAN_COL=5, once per 10-cycle period.
- VIA_PB=4'b0011 (bit3=0) -> LATCH[3]=0; VIA_PA=8'h35 (col 5, row 3) -> SCAN_COL=5 next edge, KB_PA7=1 the edge after. Change to row 2 -> KB_PA7=0.
- Manual mode, DIP=8'b0000_0100, VIA_PA=8'h04 (col 4, row 0) -> KB_PA7=1, KB_CA2=0. VIA_PA=8'h0C (col 12) -> KB_PA7=0.
- VIA_PA=8'h9F, VIA_PB=4'b0000 -> SOUND_WR=1 one cycle with SOUND_DATA=8'h9F; hold PB for 5 cycles -> no further strobe. PB=4'b1000, then 4'b0000 with PA=8'h80 -> second strobe with SOUND_DATA=8'h80.
- Assert RESET on the cycle LATCH[0] falls -> SOUND_WR stays 0 and LATCH=8'h0F; manual mode with SCAN_COL=12, then switch to autoscan -> next SCAN_COL=0.
